// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply,
// restoring divide, one-cycle fast path for divide-by-zero and overflow.
module muldiv_unit #(
    parameter int DWIDTH    = 32,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [2:0]           i_op,
    input  logic [DWIDTH-1:0]    i_op1,
    input  logic [DWIDTH-1:0]    i_op2,
    input  logic [TAG_WIDTH-1:0] i_tag,
    input  logic                 i_flush,
    output logic                 o_valid,
    output logic [DWIDTH-1:0]    o_result,
    output logic [TAG_WIDTH-1:0] o_tag
);

    localparam int CW = $clog2(DWIDTH + 1);
    localparam logic [DWIDTH-1:0] MIN = {1'b1, {(DWIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [2:0]          op_q;
    logic                neg_q;
    logic                rneg_q;
    logic [DWIDTH-1:0]   mag1;
    logic [DWIDTH-1:0]   mag2;
    logic [2*DWIDTH-1:0] prod;
    logic [DWIDTH-1:0]   rem;
    logic [DWIDTH-1:0]   quot;

    logic                op1_signed;
    logic                op2_signed;
    logic                s1;
    logic                s2;
    logic [DWIDTH-1:0]   mag1_in;
    logic [DWIDTH-1:0]   mag2_in;
    logic                div_zero;
    logic                ovf;
    logic                fast;
    logic [DWIDTH-1:0]   fast_res;
    logic                accept;

    logic [DWIDTH:0]     mul_sum;
    logic [2*DWIDTH-1:0] mul_next;
    logic [DWIDTH:0]     div_shift;
    logic [DWIDTH:0]     div_diff;
    logic                div_ge;
    logic [DWIDTH:0]     rem_next;
    logic [DWIDTH-1:0]   quot_next;
    logic [2*DWIDTH-1:0] prod_fix;
    logic [DWIDTH-1:0]   quot_fix;
    logic [DWIDTH-1:0]   rem_fix;
    logic [DWIDTH-1:0]   final_res;

    assign o_ready = (state == IDLE);
    assign accept  = (state == IDLE) && i_valid && !i_flush;

    always_comb begin
        op1_signed = 1'b0;
        op2_signed = 1'b0;
        unique case (i_op)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                op1_signed = 1'b1;
                op2_signed = 1'b1;
            end
            3'b010:  op1_signed = 1'b1;
            default: ;
        endcase
    end

    assign s1      = op1_signed & i_op1[DWIDTH-1];
    assign s2      = op2_signed & i_op2[DWIDTH-1];
    assign mag1_in = s1 ? -i_op1 : i_op1;
    assign mag2_in = s2 ? -i_op2 : i_op2;

    assign div_zero = i_op[2] && (i_op2 == '0);
    assign ovf      = i_op[2] && !i_op[0] &&
                      (i_op1 == MIN) && (i_op2 == '1);
    assign fast     = div_zero || ovf;

    always_comb begin
        fast_res = '0;
        unique case (1'b1)
            div_zero && !i_op[1]: fast_res = '1;
            div_zero && i_op[1]:  fast_res = i_op1;
            ovf && !i_op[1]:      fast_res = MIN;
            default:              fast_res = '0;
        endcase
    end

    // Low half of prod holds the remaining multiplier bits.
    assign mul_sum  = {1'b0, prod[2*DWIDTH-1:DWIDTH]} +
                      (prod[0] ? {1'b0, mag1} : '0);
    assign mul_next = {mul_sum, prod[DWIDTH-1:1]};

    assign div_shift = {rem, quot[DWIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mag2};
    assign div_ge    = !div_diff[DWIDTH];
    assign rem_next  = div_ge ? div_diff : div_shift;
    assign quot_next = {quot[DWIDTH-2:0], div_ge};

    assign prod_fix = neg_q ? -mul_next : mul_next;
    assign quot_fix = neg_q ? -quot_next : quot_next;
    assign rem_fix  = rneg_q ? -rem_next[DWIDTH-1:0]
                             : rem_next[DWIDTH-1:0];

    always_comb begin
        final_res = '0;
        unique case (1'b1)
            op_q[2] && op_q[1]:   final_res = rem_fix;
            op_q[2] && !op_q[1]:  final_res = quot_fix;
            op_q == 3'b000:       final_res = prod_fix[DWIDTH-1:0];
            default:              final_res = prod_fix[2*DWIDTH-1:DWIDTH];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            o_valid  <= 1'b0;
            o_result <= '0;
            o_tag    <= '0;
            cnt      <= '0;
        end else if (i_flush) begin
            state   <= IDLE;
            o_valid <= 1'b0;
            cnt     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    o_valid <= 1'b0;
                    if (i_valid) begin
                        o_tag <= i_tag;
                        if (fast) begin
                            o_result <= fast_res;
                            o_valid  <= 1'b1;
                            state    <= DONE;
                        end else begin
                            cnt   <= CW'(DWIDTH);
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        o_result <= final_res;
                        o_valid  <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    o_valid <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    o_valid <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Datapath needs no reset: it is always loaded on accept before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q   <= i_op;
            neg_q  <= s1 ^ s2;
            rneg_q <= s1;
            mag1   <= mag1_in;
            mag2   <= mag2_in;
            prod   <= {{DWIDTH{1'b0}}, mag2_in};
            rem    <= '0;
            quot   <= mag1_in;
        end else if (state == BUSY) begin
            prod <= mul_next;
            rem  <= rem_next[DWIDTH-1:0];
            quot <= quot_next;
        end
    end

endmodule
